// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for the bit-serial adder.
// The master drives operands and out_ready; the slave returns the result.
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             carry_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             zero;
  logic             busy;

  modport master (
    output in_valid, op_a, op_b, carry_in, out_ready,
    input  in_ready, out_valid, result, carry_out, zero, busy
  );

  modport slave (
    input  in_valid, op_a, op_b, carry_in, out_ready,
    output in_ready, out_valid, result, carry_out, zero, busy
  );
endinterface

// File: rtl/serial_adder_unit.sv
// Bit-serial adder: two half-adder stages and a carry flop add two WIDTH-bit
// operands LSB-first, one bit per clock, behind valid/ready handshakes.
module serial_adder_unit #(
  parameter int unsigned WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  serial_adder_if.slave  bus
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic             carry_q;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] result_q;
  logic             carry_out_q;
  logic             zero_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;

  logic             in_ready_d;
  logic             out_valid_d;
  logic             busy_d;

  logic             accept_c;
  logic             last_bit_c;
  logic             ha0_s_c;
  logic             ha0_c_c;
  logic             ha1_s_c;
  logic             ha1_c_c;
  logic             carry_c;
  logic [WIDTH-1:0] sum_next_c;

  // Bit-slice: half adder on the operand bits, half adder with the carry, OR of carries.
  always_comb begin
    ha0_s_c    = a_sh[0] ^ b_sh[0];
    ha0_c_c    = a_sh[0] & b_sh[0];
    ha1_s_c    = ha0_s_c ^ carry_q;
    ha1_c_c    = ha0_s_c & carry_q;
    carry_c    = ha0_c_c | ha1_c_c;
    sum_next_c = (sum_sh >> 1) | (WIDTH'(ha1_s_c) << (WIDTH - 1));
    accept_c   = bus.in_valid && (state == S_IDLE);
    last_bit_c = (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (accept_c)      state_next = S_ADD;
      S_ADD:   if (last_bit_c)    state_next = S_DONE;
      S_DONE:  if (bus.out_ready) state_next = S_IDLE;
      default:                    state_next = S_IDLE;
    endcase
  end

  // Handshake flags are decoded from the next state so they register in step with it.
  always_comb begin
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    busy_d      = 1'b0;
    case (state_next)
      S_IDLE:  in_ready_d  = 1'b1;
      S_ADD:   busy_d      = 1'b1;
      S_DONE: begin
        out_valid_d = 1'b1;
        busy_d      = 1'b1;
      end
      default: in_ready_d  = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  // Shift datapath; published result/flags only change on the final bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh        <= '0;
      b_sh        <= '0;
      sum_sh      <= '0;
      carry_q     <= 1'b0;
      cnt         <= '0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept_c) begin
            a_sh    <= bus.op_a;
            b_sh    <= bus.op_b;
            carry_q <= bus.carry_in;
            sum_sh  <= '0;
            cnt     <= '0;
          end
        end
        S_ADD: begin
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          carry_q <= carry_c;
          sum_sh  <= sum_next_c;
          cnt     <= cnt + CW'(1);
          if (last_bit_c) begin
            result_q    <= sum_next_c;
            carry_out_q <= carry_c;
            zero_q      <= (sum_next_c == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.result    = result_q;
  assign bus.carry_out = carry_out_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_serial_adder_unit.sv
// Scoreboard bench for serial_adder_unit at WIDTH=8 and WIDTH=1: expected sums
// come from plain integer addition and are checked by per-instance monitors.
module tb_serial_adder_unit;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_adder_if #(.WIDTH(8)) b8 ();
  serial_adder_if #(.WIDTH(1)) b1 ();

  serial_adder_unit #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .bus(b8));
  serial_adder_unit #(.WIDTH(1)) u1 (.clk(clk), .rst(rst), .bus(b1));

  typedef struct packed { logic [7:0] r; logic c; logic z; } exp8_t;
  typedef struct packed { logic r; logic c; logic z; } exp1_t;

  exp8_t q8[$];
  exp1_t q1[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic exp8_t model8(input logic [7:0] a, input logic [7:0] b, input logic cin);
    int unsigned s;
    exp8_t e;
    s   = int'(a) + int'(b) + int'(cin);
    e.r = 8'(s % 256);
    e.c = (s >= 256);
    e.z = ((s % 256) == 0);
    return e;
  endfunction

  function automatic exp1_t model1(input logic a, input logic b, input logic cin);
    int unsigned s;
    exp1_t e;
    s   = int'(a) + int'(b) + int'(cin);
    e.r = (s % 2) == 1;
    e.c = (s >= 2);
    e.z = ((s % 2) == 0);
    return e;
  endfunction

  // Monitors: sample mid-cycle, predicting the handshakes at the next rising edge.
  always @(negedge clk) begin
    exp8_t e;
    if (rst) begin
      q8.delete();
    end else begin
      if (b8.out_valid && b8.out_ready) begin
        if (q8.size() == 0) check("w8_unexpected_result", 32'd1, 32'd0);
        else begin
          e = q8.pop_front();
          check("w8_result", 32'(b8.result), 32'(e.r));
          check("w8_carry_out", 32'(b8.carry_out), 32'(e.c));
          check("w8_zero", 32'(b8.zero), 32'(e.z));
        end
      end
      if (b8.in_valid && b8.in_ready) q8.push_back(model8(b8.op_a, b8.op_b, b8.carry_in));
    end
  end

  always @(negedge clk) begin
    exp1_t e;
    if (rst) begin
      q1.delete();
    end else begin
      if (b1.out_valid && b1.out_ready) begin
        if (q1.size() == 0) check("w1_unexpected_result", 32'd1, 32'd0);
        else begin
          e = q1.pop_front();
          check("w1_result", 32'(b1.result), 32'(e.r));
          check("w1_carry_out", 32'(b1.carry_out), 32'(e.c));
          check("w1_zero", 32'(b1.zero), 32'(e.z));
        end
      end
      if (b1.in_valid && b1.in_ready) q1.push_back(model1(b1.op_a[0], b1.op_b[0], b1.carry_in));
    end
  end

  // Drivers run at 1ns after a rising edge and return at the same phase.
  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic cin, input bit rnd);
    bit done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      if (rnd) b8.out_ready = 1'($urandom_range(0, 1));
      if (b8.in_ready) begin
        b8.in_valid = 1'b1; b8.op_a = a; b8.op_b = b; b8.carry_in = cin;
        @(posedge clk); #1;
        b8.in_valid = 1'b0;
        done = 1'b1;
      end else begin
        @(posedge clk); #1;
      end
    end
    if (!done) check("w8_send_timeout", 32'd0, 32'd1);
  endtask

  task automatic send1(input logic a, input logic b, input logic cin, input bit rnd);
    bit done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      if (rnd) b1.out_ready = 1'($urandom_range(0, 1));
      if (b1.in_ready) begin
        b1.in_valid = 1'b1; b1.op_a = a; b1.op_b = b; b1.carry_in = cin;
        @(posedge clk); #1;
        b1.in_valid = 1'b0;
        done = 1'b1;
      end else begin
        @(posedge clk); #1;
      end
    end
    if (!done) check("w1_send_timeout", 32'd0, 32'd1);
  endtask

  // Waits for out_valid; reports cycles elapsed and whether in_ready stayed low.
  task automatic wait_valid8(output int lat, output bit ready_low);
    int t0 = cyc;
    bit seen = 1'b0;
    ready_low = 1'b1;
    for (int k = 0; k < 50 && !seen; k++) begin
      if (b8.out_valid) seen = 1'b1;
      else begin
        if (b8.in_ready) ready_low = 1'b0;
        @(posedge clk); #1;
      end
    end
    if (!seen) check("w8_valid_timeout", 32'd0, 32'd1);
    lat = cyc - t0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int  lat;
    bit  rlow;
    bit  stable;
    int  t1;
    int  t2;
    bit  stray;

    rst = 1'b1;
    b8.in_valid = 1'b0; b8.op_a = '0; b8.op_b = '0; b8.carry_in = 1'b0; b8.out_ready = 1'b0;
    b1.in_valid = 1'b0; b1.op_a = '0; b1.op_b = '0; b1.carry_in = 1'b0; b1.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(b8.out_valid), 32'd0);
    check("rst_result", 32'(b8.result), 32'd0);
    check("rst_carry_out", 32'(b8.carry_out), 32'd0);
    check("rst_zero", 32'(b8.zero), 32'd0);
    check("rst_busy", 32'(b8.busy), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_in_ready", 32'(b8.in_ready), 32'd1);
    check("w1_idle_in_ready", 32'(b1.in_ready), 32'd1);

    // Latency and in_ready low through ADD
    b8.out_ready = 1'b1;
    send8(8'h0F, 8'h01, 1'b0, 1'b0);
    wait_valid8(lat, rlow);
    check("t1_latency", 32'(lat), 32'd8);
    check("t1_in_ready_low_add", 32'(rlow), 32'd1);
    check("t1_in_ready_low_done", 32'(b8.in_ready), 32'd0);
    check("t1_busy_done", 32'(b8.busy), 32'd1);
    @(posedge clk); #1;

    // Overflow wrap to zero
    send8(8'hFF, 8'h01, 1'b0, 1'b0);
    send8(8'h7F, 8'h80, 1'b1, 1'b0);
    wait_valid8(lat, rlow);
    @(posedge clk); #1;

    // Backpressure: result held, operand pulses ignored
    b8.out_ready = 1'b0;
    send8(8'h55, 8'hAA, 1'b0, 1'b0);
    wait_valid8(lat, rlow);
    stable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      b8.in_valid = 1'($urandom_range(0, 1)); b8.op_a = 8'h11; b8.op_b = 8'h22;
      if (b8.result !== 8'hFF || b8.carry_out !== 1'b0 || b8.out_valid !== 1'b1 ||
          b8.in_ready !== 1'b0 || b8.zero !== 1'b0) stable = 1'b0;
      @(posedge clk); #1;
    end
    check("t3_hold_stable", 32'(stable), 32'd1);
    b8.in_valid = 1'b0;
    b8.out_ready = 1'b1;
    @(posedge clk); #1;
    check("t3_release_idle", 32'(b8.in_ready), 32'd1);
    check("t3_release_out_valid", 32'(b8.out_valid), 32'd0);

    // Reset after bit 3 is processed
    send8(8'h12, 8'h34, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("t4_rst_out_valid", 32'(b8.out_valid), 32'd0);
    check("t4_rst_busy", 32'(b8.busy), 32'd0);
    check("t4_rst_result", 32'(b8.result), 32'd0);
    check("t4_rst_carry_out", 32'(b8.carry_out), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    stray = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (b8.out_valid) stray = 1'b1;
      @(posedge clk); #1;
    end
    check("t4_no_out_valid", 32'(stray), 32'd0);
    send8(8'h12, 8'h34, 1'b0, 1'b0);
    wait_valid8(lat, rlow);
    @(posedge clk); #1;

    // Back-to-back accept spacing
    b8.out_ready = 1'b1;
    b8.in_valid = 1'b1; b8.op_a = 8'h01; b8.op_b = 8'h01; b8.carry_in = 1'b0;
    t1 = -1; t2 = -1;
    for (int k = 0; k < 40 && t1 < 0; k++) begin
      if (b8.in_ready) t1 = cyc;
      @(posedge clk); #1;
    end
    b8.op_a = 8'h80; b8.op_b = 8'h80;
    for (int k = 0; k < 40 && t2 < 0; k++) begin
      if (b8.in_ready) t2 = cyc;
      @(posedge clk); #1;
    end
    b8.in_valid = 1'b0;
    check("t5_accept_spacing", 32'(t2 - t1), 32'd10);
    repeat (12) @(posedge clk);
    #1;

    // Random stimulus with random backpressure and gaps
    for (int n = 0; n < 1000; n++) begin
      send8(8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
      if ($urandom_range(0, 7) == 0) begin
        @(posedge clk); #1;
      end
    end
    b8.out_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;

    // WIDTH=1 instance
    b1.out_ready = 1'b1;
    send1(1'b1, 1'b1, 1'b1, 1'b0);
    for (int n = 0; n < 1000; n++) begin
      send1(1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
    end
    b1.out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("w1_idle_busy", 32'(b1.busy), 32'd0);

    check("w8_queue_drained", 32'(q8.size()), 32'd0);
    check("w1_queue_drained", 32'(q1.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
